pdm_clk_divider: RTL and testbench
==================================

// Module: pdm_clk_divider
// PURPOSE
//  Programmable PDM microphone clock generator: divides clk to m_clk, with half-period set at runtime.
//  Emits single-cycle edge strobes plus delayed left/right sample strobes.
//  These act as clock enables in the clk domain for the downstream PDM capture/decimation logic.
//  m_clk itself only drives the microphone pin; no FPGA logic is clocked by it.
// PARAMETERS
//  INPUT_FREQ    100000000  clk frequency, Hz
//  OUTPUT_FREQ   2500000    default m_clk frequency, Hz; DEF_HALF = INPUT_FREQ/(2*OUTPUT_FREQ) (=20)
//  DIV_W         8          width of div_half input and of the half-period counter
//  SAMPLE_DELAY  2          clk cycles from an m_clk edge strobe to its sample strobe, range 0..15
// PORTS
//  clk           in   1      system clock
//  rst           in   1      reset, synchronous, active-low
//  en            in   1      run request
//  div_half      in   DIV_W  m_clk half-period in clk cycles; 0 selects DEF_HALF
//  m_clk         out  1      clock to microphone
//  m_clk_rising  out  1      1-cycle strobe, high in the same cycle m_clk goes 0->1
//  m_clk_falling out  1      1-cycle strobe, high in the same cycle m_clk goes 1->0
//  sample_r      out  1      m_clk_rising delayed by SAMPLE_DELAY cycles (right-channel capture)
//  sample_l      out  1      m_clk_falling delayed by SAMPLE_DELAY cycles (left-channel capture)
//  busy          out  1      high while state != IDLE
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, counter=0, all outputs 0, delay lines cleared. Takes effect in 1 cycle, including mid-period.
//  - FSM states: IDLE, HIGH, LOW.
//    - IDLE & en=1: next cycle state=HIGH, m_clk=1, m_clk_rising=1, counter=0, half latched.
//    - HIGH: counter increments; when counter==half-1, next cycle state=LOW, m_clk=0, m_clk_falling=1, counter=0.
//    - LOW: when counter==half-1, next cycle:
//      - if en=1: state=HIGH, m_clk=1, m_clk_rising=1, half re-latched;
//      - else: state=IDLE, m_clk stays 0, no strobe.
//  - Latching: half = (div_half==0) ? DEF_HALF : div_half.
//    - Sampled only on IDLE->HIGH and LOW->HIGH transitions, so a new divider takes effect at the next period start.
//    - The current period always completes with its old value; no runt pulses.
//    - half=1 is legal: m_clk toggles every cycle (clk/2).
//  - en deasserted mid-HIGH or mid-LOW: the current period completes fully (HIGH and LOW both half cycles), then IDLE.
//  - en re-asserted before the period ends: no interruption.
//  - Duty is exactly 50%. Period = 2*half clk cycles. Strobes never overlap each other.
//  - Sample strobes come from a shift register of depth SAMPLE_DELAY.
//    - SAMPLE_DELAY=0: sample_r==m_clk_rising and sample_l==m_clk_falling, combinationally.
//    - Strobes still in flight when going IDLE are still emitted. Reset clears them.
//    - If SAMPLE_DELAY >= half, strobes still fire at edge+SAMPLE_DELAY, independently.
//  - busy falls in the same cycle state becomes IDLE.
// CONFIGURATION
//  Macro PDM_CLK_PERIOD_CNT_EN.
//  - Defined: adds output period_cnt [31:0].
//    - Increments by 1 on every m_clk_rising and wraps 0xFFFFFFFF->0.
//    - Cleared by reset. Holds its value in IDLE.
//    - Used by software to measure mic uptime.
//  - Undefined: port and logic absent. All other behaviour is identical.
// STRUCTURE
//  - Package pdm_clk_pkg: FSM state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) and function def_half(INPUT_FREQ, OUTPUT_FREQ).
//  - One sub-module, pdm_strobe_delay, instanced twice (rising/falling):
//    - parameter DELAY;
//    - ports clk, rst, d, q;
//    - behaves as a DELAY-deep shift register, or a wire when DELAY=0.
// TESTING
//  1. Defaults, div_half=0, en=1: m_clk period 40 cycles, high 20 / low 20. Rising strobe every 40 cycles; sample_r 2 cycles after each.
//  2. div_half 0 -> 5, written 7 cycles into HIGH: current period stays 40 cycles, following periods 10 cycles, no runt.
//  3. en dropped 3 cycles into HIGH (half=20): HIGH lasts 20 and LOW lasts 20, then IDLE, busy=0.
//     - sample_l still fires 2 cycles after the final falling edge.
//  4. rst=0 asserted mid-LOW with a sample strobe in flight: next cycle all outputs 0. The strobe is suppressed.
//  5. div_half=1: m_clk toggles every cycle; rising/falling strobes alternate every cycle.
//  6. With PDM_CLK_PERIOD_CNT_EN: after 100 periods period_cnt=100.
//     - Preload near 0xFFFFFFFF via force, then check the wrap to 0.

Source files
------------

// File: rtl/pdm_clk_pkg.sv
// Shared definitions for the PDM microphone clock generator.
// FSM state encoding and the default half-period helper.
package pdm_clk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // clk cycles per m_clk half-period for a requested output frequency
  function automatic int unsigned def_half(input int unsigned in_freq,
                                           input int unsigned out_freq);
    return in_freq / (2 * out_freq);
  endfunction

endpackage

// File: rtl/pdm_strobe_delay.sv
// Delays a single-cycle strobe by DELAY clk cycles; a plain wire when DELAY=0.
// Synchronous active-low reset drops any strobe still in flight.
module pdm_strobe_delay #(
  parameter int unsigned DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DELAY == 0) begin : g_wire
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_sr
      logic [DELAY-1:0] r_sr;
      logic [DELAY-1:0] w_sr_nxt;

      if (DELAY == 1) begin : g_one
        assign w_sr_nxt = d;
      end else begin : g_many
        assign w_sr_nxt = {r_sr[DELAY-2:0], d};
      end

      always_ff @(posedge clk) begin
        if (!rst) r_sr <= '0;
        else      r_sr <= w_sr_nxt;
      end

      assign q = r_sr[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/pdm_clk_divider.sv
// Programmable PDM microphone clock: m_clk, edge strobes and delayed L/R sample strobes.
// Optional PDM_CLK_PERIOD_CNT_EN adds a free-running m_clk period counter output.
module pdm_clk_divider
  import pdm_clk_pkg::*;
#(
  parameter int unsigned INPUT_FREQ   = 100000000,
  parameter int unsigned OUTPUT_FREQ  = 2500000,
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned SAMPLE_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_half,
  output logic             m_clk,
  output logic             m_clk_rising,
  output logic             m_clk_falling,
  output logic             sample_r,
  output logic             sample_l,
  output logic             busy
`ifdef PDM_CLK_PERIOD_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  localparam int unsigned      DEF_HALF   = def_half(INPUT_FREQ, OUTPUT_FREQ);
  localparam logic [DIV_W-1:0] DEF_HALF_W = DIV_W'(DEF_HALF);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_half;
  logic             r_m_clk;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_half_nxt;
  logic             w_m_clk_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_busy_nxt;
  logic [DIV_W-1:0] w_half_sel;
  logic             w_last;

  assign w_half_sel = (div_half == '0) ? DEF_HALF_W : div_half;
  assign w_last     = (r_cnt == r_half - DIV_W'(1));

  // Next-state and registered-output decode; divider is only sampled at period start
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_half_nxt  = r_half;
    w_m_clk_nxt = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_half_nxt  = w_half_sel;
          w_m_clk_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end
      end
      ST_HIGH: begin
        w_m_clk_nxt = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
          w_m_clk_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (en) begin
            w_state_nxt = ST_HIGH;
            w_half_nxt  = w_half_sel;
            w_m_clk_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_m_clk <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_m_clk <= w_m_clk_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign m_clk         = r_m_clk;
  assign m_clk_rising  = r_rise;
  assign m_clk_falling = r_fall;
  assign busy          = r_busy;

  pdm_strobe_delay #(.DELAY(SAMPLE_DELAY)) u_dly_r (
    .clk (clk),
    .rst (rst),
    .d   (r_rise),
    .q   (sample_r)
  );

  pdm_strobe_delay #(.DELAY(SAMPLE_DELAY)) u_dly_l (
    .clk (clk),
    .rst (rst),
    .d   (r_fall),
    .q   (sample_l)
  );

`ifdef PDM_CLK_PERIOD_CNT_EN
  // Counts rising edges; tracks the rising strobe so it reads N after the Nth edge
  logic [31:0] r_period_cnt;

  always_ff @(posedge clk) begin
    if (!rst)            r_period_cnt <= '0;
    else if (w_rise_nxt) r_period_cnt <= r_period_cnt + 32'(1);
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_pdm_clk_divider.sv
// Self-checking bench for pdm_clk_divider: period-level reference model plus directed literal checks.
module tb_pdm_clk_divider;

  localparam int unsigned DIV_W = 8;
  localparam int          SD    = 2;
  localparam int          DEFH  = 20;
  localparam int          MAXC  = 16384;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_half;
  logic             m_clk, m_clk_rising, m_clk_falling, sample_r, sample_l, busy;
`ifdef PDM_CLK_PERIOD_CNT_EN
  logic [31:0]      period_cnt;
`endif

  always #5 clk = ~clk;

  pdm_clk_divider #(
    .INPUT_FREQ   (100000000),
    .OUTPUT_FREQ  (2500000),
    .DIV_W        (DIV_W),
    .SAMPLE_DELAY (SD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .div_half      (div_half),
    .m_clk         (m_clk),
    .m_clk_rising  (m_clk_rising),
    .m_clk_falling (m_clk_falling),
    .sample_r      (sample_r),
    .sample_l      (sample_l),
    .busy          (busy)
`ifdef PDM_CLK_PERIOD_CNT_EN
    ,
    .period_cnt    (period_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks period start and half-length, derives waveform by arithmetic
  bit          running  = 1'b0;
  bit          model_ok = 1'b0;
  int          start    = 0;
  int          h        = DEFH;
  int          last_rst = 0;
  bit          e_m, e_r, e_f, e_b;
  bit          hist_r [MAXC];
  bit          hist_f [MAXC];
  logic [31:0] e_pc = '0;

  function automatic int sel_half(input logic [DIV_W-1:0] d);
    return (d == '0) ? DEFH : int'(d);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      running  = 1'b0;
      last_rst = cyc;
      model_ok = 1'b1;
      e_pc     = '0;
    end else if (!running) begin
      if (en) begin
        running = 1'b1;
        start   = cyc;
        h       = sel_half(div_half);
      end
    end else if (cyc == start + 2 * h) begin
      if (en) begin
        start = cyc;
        h     = sel_half(div_half);
      end else begin
        running = 1'b0;
      end
    end
    e_m = running && (cyc - start < h);
    e_r = running && (cyc == start);
    e_f = running && (cyc == start + h);
    e_b = running;
    if (e_r) e_pc = e_pc + 32'd1;
    hist_r[cyc % MAXC] = e_r;
    hist_f[cyc % MAXC] = e_f;
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      bit exp_sr, exp_sl;
      exp_sr = (cyc - SD >= last_rst) ? hist_r[(cyc - SD) % MAXC] : 1'b0;
      exp_sl = (cyc - SD >= last_rst) ? hist_f[(cyc - SD) % MAXC] : 1'b0;
      check("m_clk",         m_clk,         e_m);
      check("m_clk_rising",  m_clk_rising,  e_r);
      check("m_clk_falling", m_clk_falling, e_f);
      check("busy",          busy,          e_b);
      check("sample_r",      sample_r,      exp_sr);
      check("sample_l",      sample_l,      exp_sl);
`ifdef PDM_CLK_PERIOD_CNT_EN
      check("period_cnt",    period_cnt,    e_pc);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until the selected strobe is seen (0=rising, 1=falling), bounded
  task automatic wait_strobe(input string name, input bit fall, output int t);
    t = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if ((!fall && m_clk_rising) || (fall && m_clk_falling)) begin
        t = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: strobe timeout, got none expected one within 300 cycles", name);
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6, ta, tf, hi, sr_off, fl_off, sl_off, bz_off;
    rst      = 1'b0;
    en       = 1'b0;
    div_half = '0;
    repeat (3) tick();
    check("rst_m_clk", m_clk, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_rise",  m_clk_rising, 1'b0);
    check("rst_sr",    sample_r, 1'b0);
    rst = 1'b1;

    // Default divider: 40-cycle period, 20 high, strobes at fixed offsets
    en = 1'b1;
    wait_strobe("t1_r1", 1'b0, t1);
    wait_strobe("t1_r2", 1'b0, t2);
    check("t1_period", 32'(t2 - t1), 32'd40);
    hi = 0; sr_off = -1; fl_off = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      hi += int'(m_clk);
      if (sample_r && sr_off < 0) sr_off = k;
      if (m_clk_falling && fl_off < 0) fl_off = k;
    end
    check("t1_high_cycles", 32'(hi), 32'd20);
    check("t1_sample_r_off", 32'(sr_off), 32'd2);
    check("t1_fall_off", 32'(fl_off), 32'd20);

    // Divider change mid-HIGH takes effect at the next period
    wait_strobe("t2_r3", 1'b0, t3);
    repeat (7) tick();
    div_half = 8'd5;
    wait_strobe("t2_r4", 1'b0, t4);
    wait_strobe("t2_r5", 1'b0, t5);
    wait_strobe("t2_r6", 1'b0, t6);
    check("t2_old_period", 32'(t4 - t3), 32'd40);
    check("t2_new_period", 32'(t5 - t4), 32'd10);
    check("t2_new_period2", 32'(t6 - t5), 32'd10);

    // en drop 3 cycles into HIGH: full period then idle
    div_half = '0;
    wait_strobe("t3_r", 1'b0, ta);
    repeat (3) tick();
    en = 1'b0;
    sl_off = -1; bz_off = -1;
    for (int k = 4; k < 100; k++) begin
      tick();
      if (sample_l) sl_off = cyc - ta;
      if (!busy && bz_off < 0) bz_off = cyc - ta;
    end
    check("t3_busy_fall", 32'(bz_off), 32'd40);
    check("t3_sample_l", 32'(sl_off), 32'd22);

    // Reset mid-LOW with sample_l in flight
    en = 1'b1;
    wait_strobe("t4_f", 1'b1, tf);
    rst = 1'b0;
    tick();
    check("t4_m_clk", m_clk, 1'b0);
    check("t4_busy",  busy,  1'b0);
    check("t4_fall",  m_clk_falling, 1'b0);
    check("t4_sl",    sample_l, 1'b0);
    rst      = 1'b1;
    div_half = 8'd1;
    tick();
    check("t4_sl_suppressed", sample_l, 1'b0);

    // half=1: m_clk toggles every cycle
    wait_strobe("t5_r", 1'b0, t1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      check("t5_m_clk", m_clk, (k % 2) == 0);
      check("t5_rise", m_clk_rising, (k % 2) == 0);
      check("t5_fall", m_clk_falling, (k % 2) == 1);
    end

`ifdef PDM_CLK_PERIOD_CNT_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 100; k++) wait_strobe("t6_r", 1'b0, t2);
    check("t6_cnt100", period_cnt, 32'd100);
    en = 1'b0;
    repeat (6) tick();
    force dut.r_period_cnt = 32'hFFFF_FFFF;
    e_pc = 32'hFFFF_FFFF;
    tick();
    release dut.r_period_cnt;
    en = 1'b1;
    wait_strobe("t6_wrap", 1'b0, t2);
    check("t6_wrap_zero", period_cnt, 32'd0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) div_half = DIV_W'($urandom_range(0, 12));
    end
    en = 1'b0;
    repeat (50) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
